// File: rtl/simple_machine_pkg.sv
// Shared definitions for the simple machine: executor opcodes, sequencer states
// and the status flags derived from each sequencer state.
package simple_machine_pkg;

    localparam logic [3:0] OP_NOP        = 4'h0;
    localparam logic [3:0] OP_LOAD_CONST = 4'h1;
    localparam logic [3:0] OP_MOVE_REG   = 4'h2;
    localparam logic [3:0] OP_ADD_CONST  = 4'h3;
    localparam logic [3:0] OP_ADD_REG    = 4'h4;
    localparam logic [3:0] OP_SUB_CONST  = 4'h5;
    localparam logic [3:0] OP_SUB_REG    = 4'h6;
    localparam logic [3:0] OP_MUL_CONST  = 4'h7;
    localparam logic [3:0] OP_MUL_REG    = 4'h8;
    localparam logic [3:0] OP_HALT       = 4'hF;

    localparam int OPCODE_W = 20;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_FLUSH = 3'd4,
        S_PAUSE = 3'd5,
        S_HALT  = 3'd6,
        S_FAULT = 3'd7
    } seq_state_t;

    typedef struct packed {
        logic running;
        logic halted;
        logic fault;
    } seq_status_t;

    function automatic seq_status_t status_of(seq_state_t s);
        seq_status_t st;
        st.running = (s == S_FETCH) || (s == S_LATCH) || (s == S_EXEC) || (s == S_FLUSH);
        st.halted  = (s == S_HALT);
        st.fault   = (s == S_FAULT);
        return st;
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Program ROM and executor pins seen by the sequencer.
interface program_sequencer_if #(
    parameter int A = 4
);
    import simple_machine_pkg::*;

    // ProgData answers ProgAddr one cycle later. OpCode non-zero is the request;
    // ExecDone high acknowledges it, and the following zero OpCode retires it.
    logic [A-1:0]          ProgAddr;
    logic [OPCODE_W-1:0]   ProgData;
    logic [OPCODE_W-1:0]   OpCode;
    logic                  ExecDone;

    modport master (output ProgAddr, output OpCode, input ProgData, input ExecDone);
    modport slave  (input ProgAddr, input OpCode, output ProgData, output ExecDone);

endinterface

// File: rtl/exec_watchdog.sv
// Counts executor cycles and flags the cycle in which the count reaches TIMEOUT.
module exec_watchdog #(
    parameter int TIMEOUT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // High during the TIMEOUT-th enabled cycle, so the edge closing it is the fault edge.
    assign timeout = enable && (count >= LIMIT);

endmodule

// File: rtl/program_sequencer.sv
// Fetches opcodes from the program ROM and hands them one at a time to the executor,
// with start, halt, single-step and watchdog fault handling.
module program_sequencer
    import simple_machine_pkg::*;
#(
    parameter int A       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Start,
    input  logic                SingleStep,
    program_sequencer_if.master bus,
    output logic                Running,
    output logic                Halted,
    output logic                Fault,
    output logic [7:0]          InstrCount,
    output seq_state_t          State
);

    localparam logic [A-1:0] PC_LAST = '1;

    seq_state_t           state;
    seq_status_t          status;
    logic [A-1:0]         pc;
    logic [OPCODE_W-1:0]  opcode;
    logic [7:0]           instr_count;
    logic                 wd_clear;
    logic                 wd_enable;
    logic                 wd_timeout;

    assign wd_clear  = (state == S_LATCH);
    assign wd_enable = (state == S_EXEC);

    exec_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .timeout (wd_timeout)
    );

    // The last address ends the program instead of wrapping to 0.
    function automatic seq_state_t advance_to(logic [A-1:0] p, logic step);
        if (p == PC_LAST) return S_HALT;
        return step ? S_PAUSE : S_FETCH;
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            status      <= '0;
            pc          <= '0;
            opcode      <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_HALT, S_FAULT: begin
                    if (Start) begin
                        state       <= S_FETCH;
                        status      <= status_of(S_FETCH);
                        pc          <= '0;
                        instr_count <= '0;
                    end
                end
                S_FETCH: begin
                    state  <= S_LATCH;
                    status <= status_of(S_LATCH);
                end
                S_LATCH: begin
                    case (bus.ProgData[19:16])
                        OP_HALT: begin
                            state  <= S_HALT;
                            status <= status_of(S_HALT);
                        end
                        OP_NOP: begin
                            state  <= advance_to(pc, SingleStep);
                            status <= status_of(advance_to(pc, SingleStep));
                            if (pc != PC_LAST) pc <= pc + 1'b1;
                        end
                        default: begin
                            opcode <= bus.ProgData;
                            state  <= S_EXEC;
                            status <= status_of(S_EXEC);
                        end
                    endcase
                end
                S_EXEC: begin
                    if (bus.ExecDone) begin
                        opcode <= '0;
                        state  <= S_FLUSH;
                        status <= status_of(S_FLUSH);
                        if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
                    end else if (wd_timeout) begin
                        opcode <= '0;
                        state  <= S_FAULT;
                        status <= status_of(S_FAULT);
                    end
                end
                S_FLUSH: begin
                    state  <= advance_to(pc, SingleStep);
                    status <= status_of(advance_to(pc, SingleStep));
                    if (pc != PC_LAST) pc <= pc + 1'b1;
                end
                S_PAUSE: begin
                    if (Start) begin
                        state  <= S_FETCH;
                        status <= status_of(S_FETCH);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    status <= '0;
                    opcode <= '0;
                end
            endcase
        end
    end

    assign bus.ProgAddr = pc;
    assign bus.OpCode   = opcode;
    assign Running      = status.running;
    assign Halted       = status.halted;
    assign Fault        = status.fault;
    assign InstrCount   = instr_count;
    assign State        = state;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: synchronous ROM model, executor model with a two-cycle
// Done, a cycle-by-cycle vector table for a short program, and hand-written corner sequences.
module tb_program_sequencer;
    import simple_machine_pkg::*;

    localparam int A = 4;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        SingleStep = 1'b0;
    logic        Running;
    logic        Halted;
    logic        Fault;
    logic [7:0]  InstrCount;
    seq_state_t  dut_state;

    int checks = 0;
    int errors = 0;

    program_sequencer_if #(.A(A)) bus ();

    program_sequencer #(.A(A), .TIMEOUT(15)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .SingleStep (SingleStep),
        .bus        (bus.master),
        .Running    (Running),
        .Halted     (Halted),
        .Fault      (Fault),
        .InstrCount (InstrCount),
        .State      (dut_state)
    );

    always #5 Clock = ~Clock;

    // Synchronous program ROM
    logic [19:0] rom [16];
    logic [19:0] rom_q = 20'h0;
    always @(posedge Clock) rom_q <= rom[bus.ProgAddr];
    assign bus.ProgData = rom_q;

    // Executor: Done rises two cycles after a non-zero OpCode appears, unless hung
    logic exec_hang = 1'b0;
    int   exec_age = 0;
    logic exec_done_q = 1'b0;
    always @(posedge Clock) begin
        if (bus.OpCode == 20'h0) begin
            exec_age    <= 0;
            exec_done_q <= 1'b0;
        end else begin
            exec_age    <= exec_age + 1;
            exec_done_q <= !exec_hang && (exec_age + 1 >= 2);
        end
    end
    assign bus.ExecDone = exec_done_q;

    typedef struct {
        logic        start;
        seq_state_t  st;
        logic [19:0] op;
        logic [3:0]  addr;
        logic [7:0]  cnt;
        logic        run;
        logic        halt;
        logic        flt;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input seq_state_t st, input logic [19:0] op,
                             input logic [3:0] addr, input logic [7:0] cnt,
                             input logic run, input logic halt, input logic flt);
        check({name, ".state"}, dut_state, st);
        check({name, ".opcode"}, bus.OpCode, op);
        check({name, ".addr"}, bus.ProgAddr, addr);
        check({name, ".count"}, InstrCount, cnt);
        check({name, ".running"}, Running, run);
        check({name, ".halted"}, Halted, halt);
        check({name, ".fault"}, Fault, flt);
    endtask

    task automatic run_until(input seq_state_t target, input int budget, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (dut_state != target && n < budget);
        check({name, ".reach"}, dut_state, target);
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        step();
        Start = 1'b0;
    endtask

    task automatic load_halts();
        for (int i = 0; i < 16; i++) rom[i] = 20'hF0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        load_halts();

        // Reset
        step();
        step();
        check_all("reset", S_IDLE, 20'h0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        step();
        check_all("idle_hold", S_IDLE, 20'h0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Two-instruction program, checked every cycle; Start re-asserted during EXEC is ignored
        rom[0] = 20'h10105;
        rom[1] = 20'h30102;
        rom[2] = 20'hF0000;
        vecs[0]  = '{1'b1, S_FETCH, 20'h00000, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, S_LATCH, 20'h00000, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, S_EXEC,  20'h10105, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, S_EXEC,  20'h10105, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, S_EXEC,  20'h10105, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, S_FLUSH, 20'h00000, 4'd0, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, S_FETCH, 20'h00000, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, S_LATCH, 20'h00000, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, S_EXEC,  20'h30102, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, S_EXEC,  20'h30102, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, S_EXEC,  20'h30102, 4'd1, 8'd1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b0, S_FLUSH, 20'h00000, 4'd1, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, S_FETCH, 20'h00000, 4'd2, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, S_LATCH, 20'h00000, 4'd2, 8'd2, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{1'b0, S_HALT,  20'h00000, 4'd2, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, S_HALT,  20'h00000, 4'd2, 8'd2, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 16; i++) begin
            Start = vecs[i].start;
            step();
            check_all($sformatf("prog_cyc%0d", i + 1), vecs[i].st, vecs[i].op, vecs[i].addr,
                      vecs[i].cnt, vecs[i].run, vecs[i].halt, vecs[i].flt);
        end
        Start = 1'b0;

        // NOP at address 0 is skipped without an EXEC
        load_halts();
        rom[0] = 20'h00000;
        rom[1] = 20'h10107;
        pulse_start();
        check_all("nop_fetch0", S_FETCH, 20'h0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("nop_latch0", S_LATCH, 20'h0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("nop_fetch1", S_FETCH, 20'h0, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("nop_latch1", S_LATCH, 20'h0, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0);
        step();
        check_all("nop_exec1", S_EXEC, 20'h10107, 4'd1, 8'd0, 1'b1, 1'b0, 1'b0);
        run_until(S_HALT, 40, "nop_halt");
        check_all("nop_end", S_HALT, 20'h0, 4'd2, 8'd1, 1'b0, 1'b1, 1'b0);

        // Watchdog: Done never comes, FAULT after exactly 15 EXEC cycles
        load_halts();
        rom[0] = 20'h10105;
        exec_hang = 1'b1;
        pulse_start();
        step();
        step();
        check_all("wd_exec", S_EXEC, 20'h10105, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 15; k++) begin
            step();
            check($sformatf("wd_exec_cyc%0d", k), dut_state, S_EXEC);
        end
        step();
        check_all("wd_fault", S_FAULT, 20'h0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step();
        step();
        check_all("wd_fault_hold", S_FAULT, 20'h0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        exec_hang = 1'b0;
        pulse_start();
        check_all("wd_restart", S_FETCH, 20'h0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
        run_until(S_HALT, 40, "wd_halt");
        check("wd_end.count", InstrCount, 8'd1);

        // Single-step: one instruction per Start pulse
        load_halts();
        rom[0] = 20'h10101;
        rom[1] = 20'h30102;
        rom[2] = 20'h30103;
        SingleStep = 1'b1;
        for (int p = 1; p <= 3; p++) begin
            pulse_start();
            check($sformatf("ss%0d_fetch.state", p), dut_state, S_FETCH);
            check($sformatf("ss%0d_fetch.addr", p), bus.ProgAddr, 4'(p - 1));
            run_until(S_PAUSE, 20, $sformatf("ss%0d", p));
            check_all($sformatf("ss%0d_pause", p), S_PAUSE, 20'h0, 4'(p), 8'(p), 1'b0, 1'b0, 1'b0);
            step();
            step();
            check($sformatf("ss%0d_hold.state", p), dut_state, S_PAUSE);
            check($sformatf("ss%0d_hold.count", p), InstrCount, 8'(p));
        end
        pulse_start();
        run_until(S_HALT, 20, "ss_halt");
        check_all("ss_end", S_HALT, 20'h0, 4'd3, 8'd3, 1'b0, 1'b1, 1'b0);
        SingleStep = 1'b0;

        // Full ROM of valid ops: halt after address 15 without wrapping
        for (int i = 0; i < 16; i++) rom[i] = 20'h30000 | 20'(i);
        pulse_start();
        run_until(S_HALT, 200, "full_halt");
        check_all("full_end", S_HALT, 20'h0, 4'd15, 8'd16, 1'b0, 1'b1, 1'b0);
        step();
        check("full_nowrap.addr", bus.ProgAddr, 4'd15);

        // Reset during the second instruction's EXEC
        pulse_start();
        run_until(S_FLUSH, 20, "rst_flush");
        check("rst_flush.count", InstrCount, 8'd1);
        run_until(S_EXEC, 20, "rst_exec");
        check("rst_exec.opcode", bus.OpCode, 20'h30001);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check_all("rst_mid", S_IDLE, 20'h0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("rst_idle", S_IDLE, 20'h0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
